// File: rtl/audio_dma_arbiter.sv
// audio_dma_arbiter: round-robin share of one DMA bus-master port between
// N audio channel requesters. One transfer per grant; the grant is held
// from issue until the downstream completion, then a one-cycle release gap.
module audio_dma_arbiter #(
    parameter int N      = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [N-1:0]          i_req,
    input  logic [N*ADDR_W-1:0]   i_address,
    input  logic [N-1:0]          i_enable,
    output logic [N-1:0]          o_ready,
    output logic [DATA_W-1:0]     o_rdata,
    output logic                  o_dma_request,
    output logic [ADDR_W-1:0]     o_dma_address,
    input  logic                  i_dma_ready,
    input  logic [DATA_W-1:0]     i_dma_rdata,
    output logic [N-1:0]          o_grant,
    output logic                  o_busy
);

    localparam int             PW  = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW:0]    N_L = N[PW:0];

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       win_q, win_d;
    logic [N-1:0]        grant_q, grant_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;

    logic [N-1:0]        eligible;
    logic                found;
    logic [PW-1:0]       pick;
    logic [PW:0]         idx;
    logic [PW:0]         ptr_nxt;

    // Round-robin search: first eligible requester starting at ptr, wrapping mod N.
    always_comb begin
        eligible = i_req & i_enable;
        found    = 1'b0;
        pick     = '0;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr_q} + (PW+1)'(k);
            if (idx >= N_L) idx = idx - N_L;
            if (!found && eligible[idx[PW-1:0]]) begin
                found = 1'b1;
                pick  = idx[PW-1:0];
            end
        end
    end

    // Pointer moves one past the winner so the winner goes to the back of the line.
    always_comb begin
        ptr_nxt = {1'b0, win_q} + 1'b1;
        if (ptr_nxt >= N_L) ptr_nxt = '0;
    end

    // Next-state and registered-output logic for IDLE -> ISSUE -> RELEASE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        grant_d = grant_q;
        req_d   = req_q;
        addr_d  = addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    win_d   = pick;
                    grant_d = {{(N-1){1'b0}}, 1'b1} << pick;
                    addr_d  = i_address[pick*ADDR_W +: ADDR_W];
                    req_d   = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Request and address stay frozen until the bus completes.
                if (i_dma_ready) begin
                    req_d   = 1'b0;
                    grant_d = '0;
                    ptr_d   = ptr_nxt[PW-1:0];
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // Guaranteed request-low gap; requests are not looked at here.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                grant_d = '0;
            end
        endcase
    end

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            grant_q <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            grant_q <= grant_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    // Completion is combinational from the bus; gated to ISSUE so stray readies vanish.
    always_comb begin
        o_ready = grant_q & {N{i_dma_ready & (state_q == S_ISSUE)}};
        o_rdata = i_dma_rdata;
    end

    assign o_dma_request = req_q;
    assign o_dma_address = addr_q;
    assign o_grant       = grant_q;
    assign o_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_audio_dma_arbiter.sv
// Scoreboard bench for audio_dma_arbiter: directed scenarios push expected
// completions; a negedge monitor pops and compares on every o_ready pulse.
module tb_audio_dma_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    localparam logic [31:0] ADDR_TAB [4] = '{32'h0000_0100, 32'h0000_1000,
                                             32'h0000_2200, 32'h0000_3300};

    logic          clk = 1'b0;
    logic          i_reset;
    logic [N-1:0]  i_req;
    logic [N*AW-1:0] i_address;
    logic [N-1:0]  i_enable;
    logic [N-1:0]  o_ready;
    logic [DW-1:0] o_rdata;
    logic          o_dma_request;
    logic [AW-1:0] o_dma_address;
    logic          i_dma_ready;
    logic [DW-1:0] i_dma_rdata;
    logic [N-1:0]  o_grant;
    logic          o_busy;

    always #5 clk = ~clk;

    assign i_address = {ADDR_TAB[3], ADDR_TAB[2], ADDR_TAB[1], ADDR_TAB[0]};

    audio_dma_arbiter #(.N(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clock       (clk),
        .i_reset       (i_reset),
        .i_req         (i_req),
        .i_address     (i_address),
        .i_enable      (i_enable),
        .o_ready       (o_ready),
        .o_rdata       (o_rdata),
        .o_dma_request (o_dma_request),
        .o_dma_address (o_dma_address),
        .i_dma_ready   (i_dma_ready),
        .i_dma_rdata   (i_dma_rdata),
        .o_grant       (o_grant),
        .o_busy        (o_busy)
    );

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every completion pulse must match the oldest expected transfer.
    always @(negedge clk) begin
        if (o_ready !== '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", 64'(o_ready), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("ready_onehot", 64'(o_ready), 64'(4'b0001 << mon_e.idx));
                chk("rdata", 64'(o_rdata), 64'(mon_e.rd));
                chk("dma_addr_at_ready", 64'(o_dma_address), 64'(mon_e.addr));
            end
        end
    end

    task automatic do_reset();
        i_reset = 1'b1;
        tick();
        chk("rst_req", 64'(o_dma_request), 64'd0);
        chk("rst_grant", 64'(o_grant), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd0);
        chk("rst_addr", 64'(o_dma_address), 64'd0);
        tick();
        i_reset = 1'b0;
    endtask

    // One transfer: wait for the downstream request, then complete it after lat ISSUE cycles.
    task automatic xfer(input int idx, input int lat, input logic [31:0] rd,
                        input logic [3:0] en_issue, output int rise);
        int t;
        sb.push_back('{idx, ADDR_TAB[idx], rd});
        t = 0;
        do begin
            tick();
            t++;
        end while (!o_dma_request && t < 20);
        rise = cyc;
        if (!o_dma_request) begin
            checks++;
            failures++;
            $display("FAIL xfer_timeout: no request for idx %0d within %0d cycles", idx, t);
            return;
        end
        chk("grant", 64'(o_grant), 64'(4'b0001 << idx));
        chk("dma_addr", 64'(o_dma_address), 64'(ADDR_TAB[idx]));
        i_enable = en_issue;
        for (int i = 1; i < lat; i++) begin
            tick();
            chk("hold_req", 64'(o_dma_request), 64'd1);
            chk("hold_addr", 64'(o_dma_address), 64'(ADDR_TAB[idx]));
        end
        i_dma_ready = 1'b1;
        i_dma_rdata = rd;
        tick();
        i_dma_ready = 1'b0;
        i_dma_rdata = '0;
        chk("release_req_low", 64'(o_dma_request), 64'd0);
        chk("release_grant", 64'(o_grant), 64'd0);
        chk("release_busy", 64'(o_busy), 64'd1);
    endtask

    initial begin
        int r, prev, c0;
        i_reset     = 1'b1;
        i_req       = '0;
        i_enable    = 4'hF;
        i_dma_ready = 1'b0;
        i_dma_rdata = '0;
        do_reset();

        // Single requester, 3-cycle downstream latency, 1-cycle request latency.
        i_req = 4'b0010;
        c0 = cyc;
        xfer(1, 3, 32'hDEAD_BEEF, 4'hF, r);
        chk("req_latency", 64'(r - c0), 64'd1);
        i_req = '0;
        tick();
        chk("idle_after_release", 64'(o_busy), 64'd0);
        chk("idle_req_low", 64'(o_dma_request), 64'd0);

        // All four requesting continuously: 0,1,2,3,0,1 at 3 cycles each.
        do_reset();
        i_req = 4'hF;
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            xfer(i % 4, 1, 32'hA000_0000 + 32'(i), 4'hF, r);
            if (i > 0) chk("rr_period", 64'(r - prev), 64'd3);
            prev = r;
        end
        i_req = '0;
        tick();
        tick();

        // Pointer rotation: after 2, request {3,0} -> 3 then 0.
        do_reset();
        i_req = 4'b0100;
        xfer(2, 1, 32'h0000_0002, 4'hF, r);
        i_req = 4'b1001;
        xfer(3, 1, 32'h0000_0003, 4'hF, r);
        i_req = 4'b0001;
        xfer(0, 2, 32'h0000_0010, 4'hF, r);
        i_req = '0;
        tick();
        tick();

        // Mask 1010: grants 1,3,1,3; enable[3] dropped mid-transfer, next grant 1.
        do_reset();
        i_enable = 4'b1010;
        i_req    = 4'hF;
        xfer(1, 1, 32'h1111_0001, 4'b1010, r);
        xfer(3, 1, 32'h3333_0001, 4'b1010, r);
        xfer(1, 1, 32'h1111_0002, 4'b1010, r);
        xfer(3, 2, 32'h3333_0002, 4'b0010, r);
        xfer(1, 1, 32'h1111_0003, 4'b0010, r);
        i_req    = '0;
        i_enable = 4'hF;
        tick();
        tick();

        // Reset mid-ISSUE (ptr is 2 here), then stray ready, then lowest-index grant.
        i_req = 4'b1000;
        tick();
        chk("pre_reset_grant", 64'(o_grant), 64'(4'b1000));
        chk("pre_reset_req", 64'(o_dma_request), 64'd1);
        i_reset = 1'b1;
        i_req   = '0;
        tick();
        i_reset = 1'b0;
        chk("mid_rst_req", 64'(o_dma_request), 64'd0);
        chk("mid_rst_grant", 64'(o_grant), 64'd0);
        chk("mid_rst_busy", 64'(o_busy), 64'd0);
        chk("mid_rst_addr", 64'(o_dma_address), 64'd0);
        i_dma_ready = 1'b1;
        i_dma_rdata = 32'hBAD0_BAD0;
        #1;
        chk("stray_ready_after_rst", 64'(o_ready), 64'd0);
        tick();
        i_dma_ready = 1'b0;
        i_dma_rdata = '0;
        chk("stray_busy", 64'(o_busy), 64'd0);
        i_req = 4'b1010;
        xfer(1, 1, 32'h5555_0001, 4'hF, r);
        i_req = '0;
        tick();
        tick();

        // Spurious ready in IDLE: no pulse, pointer (now 2) unchanged -> {3,1,0} picks 3.
        i_dma_ready = 1'b1;
        i_dma_rdata = 32'hFFFF_0000;
        #1;
        chk("spurious_ready", 64'(o_ready), 64'd0);
        tick();
        i_dma_ready = 1'b0;
        i_dma_rdata = '0;
        chk("spurious_busy", 64'(o_busy), 64'd0);
        i_req = 4'b1011;
        xfer(3, 1, 32'h6666_0003, 4'hF, r);
        i_req = '0;
        tick();
        tick();

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
